systolic_array_os_nxn: RTL

- Parametrised NxN output-stationary signed MAC array with built-in input skewing, control FSM and result drain/readout.
- Computes C = A·B over a runtime depth k_len: each beat supplies one A column (N elements) and one B row (N elements).
- Successor to the fixed 4x4 array; sits between the LSTM weight/activation streamers and the accumulator/activation stage.

---
 rtl/systolic_array_os_nxn.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_os_nxn.sv
// -----------------------------------------------------------------------------
// systolic_array_os_nxn
//
// Parametrised NxN output-stationary signed MAC array. Each accepted beat
// carries one column of A and one row of B. The operands are skewed inside
// the block, so the caller streams plain, unskewed beats. After a zero-operand
// drain, the block reads out the N result rows one at a time using a
// valid/ready handshake.
//
// Optional build macro: SYSTOLIC_SATURATE_EN
//   When defined, every accumulation clamps to the signed ACC_W range, and
//   the sat_flag output reports a clamp in the current operation. When
//   undefined, accumulators wrap modulo 2^ACC_W and sat_flag does not exist.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, k_len     start an operation with a depth of k_len beats (IDLE only)
//   in_valid/ready   beat handshake; a_col feeds rows, b_row feeds columns
//   out_valid/ready  result row handshake; out_row_idx selects the row in c_row
//   c_row            N accumulators of the presented row, ACC_W bits each
//   busy, done       operation in flight / one-cycle completion pulse
//   sat_flag         sticky clamp indicator (SYSTOLIC_SATURATE_EN only)
// -----------------------------------------------------------------------------
module systolic_array_os_nxn #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+8,
   parameter int KLEN_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KLEN_W-1:0]     k_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_W-1:0]   a_col,
   input  logic [N*DATA_W-1:0]   b_row,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [$clog2(N)-1:0]  out_row_idx,
   output logic [N*ACC_W-1:0]    c_row,
   output logic                  busy,
`ifdef SYSTOLIC_SATURATE_EN
   output logic                  sat_flag,
`endif
   output logic                  done
);

   localparam int RW = $clog2(N);
   localparam int DW = $clog2(2*N);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUT} state_t;

   state_t                    state_q, state_d;
   logic [KLEN_W-1:0]         kLen_q;
   logic [KLEN_W-1:0]         beatCnt_q, beatCnt_d;
   logic [DW-1:0]             drainCnt_q, drainCnt_d;
   logic [RW-1:0]             rowIdx_q, rowIdx_d;
   logic                      done_q, done_d;
   logic                      startOp, advance, zeroOps;

   logic signed [DATA_W-1:0]   aHead [N];
   logic signed [DATA_W-1:0]   bHead [N];
   logic signed [DATA_W-1:0]   aRowIn [N];
   logic signed [DATA_W-1:0]   bColIn [N];
   logic signed [DATA_W-1:0]   aIn [N][N];
   logic signed [DATA_W-1:0]   bIn [N][N];
   logic signed [DATA_W-1:0]   aSkew_q [N][N-1];
   logic signed [DATA_W-1:0]   bSkew_q [N][N-1];
   logic signed [DATA_W-1:0]   aPipe_q [N][N-1];
   logic signed [DATA_W-1:0]   bPipe_q [N-1][N];
   logic signed [2*DATA_W-1:0] prod [N][N];
   logic signed [ACC_W-1:0]    prodExt [N][N];
   logic signed [ACC_W-1:0]    acc_q [N][N];
   logic signed [ACC_W-1:0]    acc_d [N][N];

   // Control FSM next-state logic. The array only moves on an "advance".
   // In STREAM, an advance needs an accepted beat. In DRAIN, the array
   // advances every cycle and zeros are fed in, which pushes the last skewed
   // operands through to the far corner PE.
   always_comb begin
      state_d    = state_q;
      beatCnt_d  = beatCnt_q;
      drainCnt_d = drainCnt_q;
      rowIdx_d   = rowIdx_q;
      done_d     = 1'b0;
      startOp    = 1'b0;
      advance    = 1'b0;
      zeroOps    = 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               startOp    = 1'b1;
               beatCnt_d  = '0;
               drainCnt_d = '0;
               rowIdx_d   = '0;
               state_d    = (k_len != '0) ? STREAM : DRAIN;
            end
         end
         STREAM: begin
            zeroOps = 1'b0;
            if (in_valid) begin
               advance = 1'b1;
               if (beatCnt_q == kLen_q - KLEN_W'(1)) begin
                  beatCnt_d = '0;
                  state_d   = DRAIN;
               end else begin
                  beatCnt_d = beatCnt_q + KLEN_W'(1);
               end
            end
         end
         DRAIN: begin
            advance = 1'b1;
            if (drainCnt_q == DW'(2*N-2)) begin
               drainCnt_d = '0;
               state_d    = OUT;
            end else begin
               drainCnt_d = drainCnt_q + DW'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               if (rowIdx_q == RW'(N-1)) begin
                  rowIdx_d = '0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  rowIdx_d = rowIdx_q + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers. k_len is captured only when an operation starts,
   // so later changes on the input have no effect on the running operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         kLen_q     <= '0;
         beatCnt_q  <= '0;
         drainCnt_q <= '0;
         rowIdx_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beatCnt_q  <= beatCnt_d;
         drainCnt_q <= drainCnt_d;
         rowIdx_q   <= rowIdx_d;
         done_q     <= done_d;
         if (startOp) begin
            kLen_q <= k_len;
         end
      end
   end

   // Operand routing. Row i's A operand comes out of an i-deep delay line,
   // and column j's B operand comes out of a j-deep delay line. Inside the
   // array, A moves one PE to the right per advance and B moves one PE down.
   // As a result, A[i][t] and B[t][j] meet in PE(i,j) on advance t+i+j.
   always_comb begin
      aHead   = '{default: '0};
      bHead   = '{default: '0};
      aRowIn  = '{default: '0};
      bColIn  = '{default: '0};
      aIn     = '{default: '0};
      bIn     = '{default: '0};
      prod    = '{default: '0};
      prodExt = '{default: '0};
      for (int i = 0; i < N; i++) begin
         aHead[i] = zeroOps ? '0 : a_col[i*DATA_W +: DATA_W];
         bHead[i] = zeroOps ? '0 : b_row[i*DATA_W +: DATA_W];
      end
      aRowIn[0] = aHead[0];
      bColIn[0] = bHead[0];
      for (int i = 1; i < N; i++) begin
         aRowIn[i] = aSkew_q[i][i-1];
         bColIn[i] = bSkew_q[i][i-1];
      end
      for (int i = 0; i < N; i++) begin
         aIn[i][0] = aRowIn[i];
         bIn[0][i] = bColIn[i];
         for (int j = 1; j < N; j++) begin
            aIn[i][j] = aPipe_q[i][j-1];
            bIn[j][i] = bPipe_q[j-1][i];
         end
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            prod[i][j]    = aIn[i][j] * bIn[i][j];
            prodExt[i][j] = prod[i][j];
         end
      end
   end

`ifdef SYSTOLIC_SATURATE_EN
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

   logic [ACC_W:0] wideSum [N][N];
   logic           satHit;
   logic           satFlag_q;

   // Saturating accumulate. The sum is formed one bit wider than ACC_W.
   // If its top two bits differ, the true result is out of range, and the
   // accumulator clamps toward the sign of that true result.
   always_comb begin
      wideSum = '{default: '0};
      acc_d   = '{default: '0};
      satHit  = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            wideSum[i][j] = {acc_q[i][j][ACC_W-1], acc_q[i][j]}
                          + {prodExt[i][j][ACC_W-1], prodExt[i][j]};
            if (wideSum[i][j][ACC_W] != wideSum[i][j][ACC_W-1]) begin
               acc_d[i][j] = wideSum[i][j][ACC_W] ? ACC_MIN : ACC_MAX;
               satHit      = 1'b1;
            end else begin
               acc_d[i][j] = wideSum[i][j][ACC_W-1:0];
            end
         end
      end
   end

   // Sticky clamp flag. It is cleared when an operation starts and is set
   // by any clamping advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         satFlag_q <= 1'b0;
      end else if (startOp) begin
         satFlag_q <= 1'b0;
      end else if (advance && satHit) begin
         satFlag_q <= 1'b1;
      end
   end

   assign sat_flag = satFlag_q;
`else
   // Plain accumulate. Any overflow wraps modulo 2^ACC_W.
   always_comb begin
      acc_d = '{default: '0};
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            acc_d[i][j] = acc_q[i][j] + prodExt[i][j];
         end
      end
   end
`endif

   // Array state. Starting an operation clears the accumulators and the
   // operand pipelines, so a new operation never sees leftover operands.
   // When nothing advances, every register holds its value. That is why
   // gaps in in_valid cannot misalign the skewed operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aSkew_q <= '{default: '0};
         bSkew_q <= '{default: '0};
         aPipe_q <= '{default: '0};
         bPipe_q <= '{default: '0};
         acc_q   <= '{default: '0};
      end else if (startOp) begin
         aSkew_q <= '{default: '0};
         bSkew_q <= '{default: '0};
         aPipe_q <= '{default: '0};
         bPipe_q <= '{default: '0};
         acc_q   <= '{default: '0};
      end else if (advance) begin
         for (int i = 0; i < N; i++) begin
            aSkew_q[i][0] <= aHead[i];
            bSkew_q[i][0] <= bHead[i];
            for (int d = 1; d < N-1; d++) begin
               aSkew_q[i][d] <= aSkew_q[i][d-1];
               bSkew_q[i][d] <= bSkew_q[i][d-1];
            end
            for (int j = 0; j < N-1; j++) begin
               aPipe_q[i][j] <= aIn[i][j];
               bPipe_q[j][i] <= bIn[j][i];
            end
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= acc_d[i][j];
            end
         end
      end
   end

   // Readout. c_row shows the selected row only while OUT presents it, and
   // is zero otherwise.
   always_comb begin
      c_row = '0;
      if (state_q == OUT) begin
         for (int j = 0; j < N; j++) begin
            c_row[j*ACC_W +: ACC_W] = acc_q[rowIdx_q][j];
         end
      end
   end

   assign in_ready    = (state_q == STREAM);
   assign out_valid   = (state_q == OUT);
   assign busy        = (state_q != IDLE);
   assign out_row_idx = rowIdx_q;
   assign done        = done_q;

endmodule
